mult_div_unit: RTL and testbench

- Multi-cycle MIPS multiply/divide unit that owns the HI/LO registers.
- Sits directly downstream of the register file: operands come from sourceReg (rs) and secondaryReg (rt), sampled on a start strobe.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle. Results stay in HI/LO for MFHI/MFLO.
- Supports MTHI/MTLO writes while idle.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mult_div_unit.sv | 125 ++++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: op codes, FSM states, default width.
package mips_pkg;

    localparam int MDU_DATA_W = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle through a shared
// adder/subtractor acting on a combined accumulator/shift register.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] srcA,
    input  logic [DATA_W-1:0] srcB,
    input  logic              hiWrite,
    input  logic              loWrite,
    input  logic [DATA_W-1:0] writeData,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    mdu_state_t          state;
    mdu_op_t             op_r;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic                res_neg;
    logic                rem_neg;
    logic [CW-1:0]       cnt;
    // mult: {carry, partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [2*DATA_W:0]   acc;

    logic                in_signed, in_mul, sa, sb, is_mul;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic [2*DATA_W:0]   sh, acc_next;
    logic [DATA_W:0]     add_x, add_y, add_s;
    logic [2*DATA_W-1:0] prod, prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    always_comb begin
        in_signed = (mdu_op_t'(op) == MDU_MULT) || (mdu_op_t'(op) == MDU_DIV);
        in_mul    = (mdu_op_t'(op) == MDU_MULT) || (mdu_op_t'(op) == MDU_MULTU);
        sa        = in_signed & srcA[DATA_W-1];
        sb        = in_signed & srcB[DATA_W-1];
        a_abs     = sa ? -srcA : srcA;
        b_abs     = sb ? -srcB : srcB;
        is_mul    = (op_r == MDU_MULT) || (op_r == MDU_MULTU);

        sh    = {acc[2*DATA_W-1:0], 1'b0};
        add_x = is_mul ? {1'b0, acc[2*DATA_W-1:DATA_W]} : sh[2*DATA_W:DATA_W];
        add_y = {1'b0, is_mul ? a_mag : b_mag};
        add_s = is_mul ? add_x + add_y : add_x - add_y;

        if (is_mul)
            acc_next = acc[0] ? {1'b0, add_s, acc[DATA_W-1:1]} : {1'b0, acc[2*DATA_W:1]};
        else
            acc_next = add_s[DATA_W] ? sh : {add_s, sh[DATA_W-1:1], 1'b1};

        prod     = acc[2*DATA_W-1:0];
        prod_fix = res_neg ? -prod : prod;
        quo_fix  = res_neg ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        rem_fix  = rem_neg ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            op_r    <= MDU_MULT;
            a_mag   <= '0;
            b_mag   <= '0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (hiWrite) hi <= writeData;
                if (loWrite) lo <= writeData;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r    <= mdu_op_t'(op);
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        // A zero divisor keeps the all-ones quotient unsigned and the
                        // remainder sign fix then reproduces the raw dividend in HI.
                        res_neg <= (sa ^ sb) & (srcB != '0);
                        rem_neg <= sa;
                        acc     <= {{(DATA_W+1){1'b0}}, in_mul ? b_abs : a_abs};
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(DATA_W - 1)) state <= FIX;
                end
                FIX: begin
                    if (is_mul) begin
                        hi <= prod_fix[2*DATA_W-1:DATA_W];
                        lo <= prod_fix[DATA_W-1:0];
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] srcA = '0, srcB = '0, writeData = '0;
    logic        hiWrite = 1'b0, loWrite = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;

    mult_div_unit #(.DATA_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .hiWrite(hiWrite), .loWrite(loWrite),
        .writeData(writeData), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        longint          p;
        longint unsigned pu;
        int              sa, sb;
        sa = a;
        sb = b;
        case (o)
            2'd0: begin p = longint'(sa) * longint'(sb); h = p[63:32]; l = p[31:0]; end
            2'd1: begin pu = {32'h0, a} * {32'h0, b}; h = pu[63:32]; l = pu[31:0]; end
            2'd2: begin
                if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin l = 32'h8000_0000; h = 0; end
                else begin l = sa / sb; h = sa % sb; end
            end
            default: begin
                if (b == 0) begin l = 32'hFFFF_FFFF; h = a; end
                else begin l = a / b; h = a % b; end
            end
        endcase
    endfunction

    // mode: 0 plain, 1 loWrite mid-operation, 2 second start mid-operation, 3 hiWrite on start edge
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
        logic [31:0] eh, el;
        int edges, busy_n;
        model(o, a, b, eh, el);
        @(negedge Clk);
        start = 1'b1; op = o; srcA = a; srcB = b;
        if (mode == 3) begin hiWrite = 1'b1; writeData = 32'h0000_1234; end
        @(posedge Clk); #1;
        start = 1'b0; hiWrite = 1'b0;
        op = 2'($urandom); srcA = $urandom; srcB = $urandom;
        if (mode == 3) begin
            check("hi_write_on_start", hi, 32'h0000_1234);
            exp_hi = 32'h0000_1234;
        end
        busy_n = busy ? 1 : 0;
        edges = 0;
        while (!done && edges < 60) begin
            if (mode == 1 && edges == 3) begin loWrite = 1'b1; writeData = 32'd88888; end
            if (mode == 2 && edges == 4) begin start = 1'b1; op = 2'd3; srcA = 32'd100; srcB = 32'd7; end
            @(posedge Clk); #1;
            edges++;
            if (busy) busy_n++;
            if (mode == 1 && edges == 4) begin
                check("lo_write_ignored_busy", lo, exp_lo);
                loWrite = 1'b0;
            end
            if (mode == 2 && edges == 5) begin
                check("busy_after_restart", busy, 1);
                start = 1'b0;
            end
        end
        check("latency_edges", edges, 33);
        check("busy_cycles", busy_n, 33);
        check("hi_result", hi, eh);
        check("lo_result", lo, el);
        exp_hi = eh;
        exp_lo = el;
        @(posedge Clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    task automatic idle_write(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge Clk);
        hiWrite = wh; loWrite = wl; writeData = d;
        @(posedge Clk); #1;
        hiWrite = 1'b0; loWrite = 1'b0;
        if (wh) exp_hi = d;
        if (wl) exp_lo = d;
        check("idle_write_hi", hi, exp_hi);
        check("idle_write_lo", lo, exp_lo);
    endtask

    initial begin
        logic [31:0] ra, rb;
        repeat (2) @(negedge Clk);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        Reset_n = 1'b1;

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hi", exp_hi, 32'hFFFF_FFFE);
        check("multu_max_lo", exp_lo, 32'h0000_0001);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0);
        run_op(2'd3, 32'd456, 32'd7, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'd88888, 32'd0, 0);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0, 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0);

        idle_write(1'b1, 1'b0, 32'd456);
        idle_write(1'b1, 1'b1, 32'hCAFE_F00D);
        run_op(2'd1, 32'd1234, 32'd5678, 1);
        run_op(2'd1, 32'd3, 32'd4, 2);
        run_op(2'd3, 32'hDEAD_BEEF, 32'd13, 3);

        // Reset in the middle of an operation with an ignored second start.
        @(negedge Clk);
        start = 1'b1; op = 2'd1; srcA = 32'd5; srcB = 32'd5;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (4) @(posedge Clk);
        #1 start = 1'b1; op = 2'd3; srcA = 32'd9; srcB = 32'd3;
        @(posedge Clk); #1;
        start = 1'b0;
        check("busy_before_reset", busy, 1);
        repeat (4) @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1;
        check("midop_reset_hi", hi, 0);
        check("midop_reset_lo", lo, 0);
        check("midop_reset_busy", busy, 0);
        check("midop_reset_done", done, 0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1 check("idle_after_reset", busy, 0);
        run_op(2'd1, 32'd5, 32'd5, 0);
        check("fresh_multu_lo", exp_lo, 32'd25);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op(2'($urandom_range(0, 3)), ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
